// File: rtl/shift_exec_stage.sv
// Two-stage valid/ready shift execute stage built around a single logical-left barrel shifter.
// Define SHIFT_EXEC_ROTATE_EN to build ROL/ROR; otherwise those ops are reported as illegal.
module shift_exec_stage #(
  parameter int N   = 32,
  parameter int SHW = $clog2(N),
  parameter int TW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [2:0]     i_op,
  input  logic [N-1:0]   i_data,
  input  logic [SHW-1:0] i_shamt,
  input  logic [TW-1:0]  i_tag,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [N-1:0]   o_data,
  output logic [TW-1:0]  o_tag,
  output logic           o_illegal
);

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int b = 0; b < N; b++) begin
      r[b] = v[N-1-b];
    end
    return r;
  endfunction

  logic           s1_valid;
  logic [2:0]     s1_op;
  logic [N-1:0]   s1_data;
  logic [SHW-1:0] s1_shamt;
  logic [TW-1:0]  s1_tag;

  logic           s2_valid;
  logic [N-1:0]   s2_data;
  logic [TW-1:0]  s2_tag;
  logic           s2_illegal;

  logic           s2_free;
  logic [N-1:0]   shl_in;
  logic [N-1:0]   shl_out;
  logic [N-1:0]   sra_fill;
  logic [N-1:0]   result;
  logic           illegal;

  assign s2_free   = !s2_valid || o_ready;
  assign i_ready   = rst && (!s1_valid || s2_free);
  assign o_valid   = s2_valid;
  assign o_data    = s2_data;
  assign o_tag     = s2_tag;
  assign o_illegal = s2_illegal;

  // Right shifts and ROR reuse the left shifter by mirroring the operand in and the result out.
  always_comb begin
    shl_in   = s1_data;
    result   = {N{1'b0}};
    illegal  = 1'b0;
    if ((s1_op == OP_SLL) || (s1_op == OP_ROL)) begin
      shl_in = s1_data;
    end else begin
      shl_in = rev(s1_data);
    end
    shl_out  = shl_in << s1_shamt;
    sra_fill = ~({N{1'b1}} >> s1_shamt);
    case (s1_op)
      OP_SLL:  result = shl_out;
      OP_SRL:  result = rev(shl_out);
      OP_SRA:  result = rev(shl_out) | (sra_fill & {N{s1_data[N-1]}});
`ifdef SHIFT_EXEC_ROTATE_EN
      OP_ROL:  result = rotate_left(shl_in, s1_shamt);
      OP_ROR:  result = rev(rotate_left(shl_in, s1_shamt));
`endif
      default: begin
        result  = {N{1'b0}};
        illegal = 1'b1;
      end
    endcase
  end

`ifdef SHIFT_EXEC_ROTATE_EN
  // Upper half of the doubled word shifted left is the rotation; OR with the lower half is a no-op.
  function automatic logic [N-1:0] rotate_left(input logic [N-1:0] v, input logic [SHW-1:0] sh);
    logic [2*N-1:0] cat;
    cat = {v, v} << sh;
    return cat[2*N-1:N] | cat[N-1:0];
  endfunction
`endif

  // Stage 1: capture operands on an input transfer, empty when the op moves on.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_op    <= 3'b000;
      s1_data  <= {N{1'b0}};
      s1_shamt <= {SHW{1'b0}};
      s1_tag   <= {TW{1'b0}};
    end else if (i_valid && i_ready) begin
      s1_valid <= 1'b1;
      s1_op    <= i_op;
      s1_data  <= i_data;
      s1_shamt <= i_shamt;
      s1_tag   <= i_tag;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s1_valid;
    end
  end

  // Stage 2: result register; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid   <= 1'b0;
      s2_data    <= {N{1'b0}};
      s2_tag     <= {TW{1'b0}};
      s2_illegal <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data    <= result;
        s2_tag     <= s1_tag;
        s2_illegal <= illegal;
      end else begin
        s2_data    <= s2_data;
        s2_tag     <= s2_tag;
        s2_illegal <= s2_illegal;
      end
    end else begin
      s2_valid <= s2_valid;
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage; rotate expectations follow SHIFT_EXEC_ROTATE_EN.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [2:0]  i_op = 3'b000;
  logic [31:0] i_data = 32'h0;
  logic [4:0]  i_shamt = 5'd0;
  logic [3:0]  i_tag = 4'h0;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic [31:0] o_data;
  logic [3:0]  o_tag;
  logic        o_illegal;

  int vectors = 0;
  int errors  = 0;
  logic [36:0] sb[$];

  shift_exec_stage dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op), .i_data(i_data),
    .i_shamt(i_shamt), .i_tag(i_tag),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_tag(o_tag),
    .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      3'd0: return {1'b0, d << sh};
      3'd1: return {1'b0, d >> sh};
      3'd2: return {1'b0, 32'(sd >>> sh)};
`ifdef SHIFT_EXEC_ROTATE_EN
      3'd3: return {1'b0, (d << sh) | (d >> (32 - int'(sh)))};
      3'd4: return {1'b0, (d >> sh) | (d << (32 - int'(sh)))};
`endif
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Inputs and outputs only change just after a rising edge, so the falling edge sees what the next edge will use.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (i_valid && i_ready) begin
        logic [32:0] m;
        m = model(i_op, i_data, i_shamt);
        sb.push_back({m[32], i_tag, m[31:0]});
      end
      if (o_valid && o_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got data=%h tag=%h ill=%b, scoreboard empty", o_data, o_tag, o_illegal);
        end else begin
          logic [36:0] e;
          e = sb.pop_front();
          if ({o_illegal, o_tag, o_data} !== e) begin
            errors++;
            $display("FAIL result: got ill=%b tag=%h data=%h, expected ill=%b tag=%h data=%h",
                     o_illegal, o_tag, o_data, e[36], e[35:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                      input logic [3:0] tag, output int waited);
    waited = 0;
    i_valid = 1'b1; i_op = op; i_data = d; i_shamt = sh; i_tag = tag;
    @(negedge clk);
    while (i_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (i_ready !== 1'b1) begin
      vectors++; errors++;
      $display("FAIL send_timeout: i_ready=%b after %0d cycles, required 1", i_ready, waited);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain;
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    vectors++; if (o_valid !== 1'b0)     begin errors++; $display("FAIL rst_o_valid: got %b, required 0", o_valid); end
    vectors++; if (o_data !== 32'h0)     begin errors++; $display("FAIL rst_o_data: got %h, required 0", o_data); end
    vectors++; if (o_tag !== 4'h0)       begin errors++; $display("FAIL rst_o_tag: got %h, required 0", o_tag); end
    vectors++; if (o_illegal !== 1'b0)   begin errors++; $display("FAIL rst_o_illegal: got %b, required 0", o_illegal); end
    vectors++; if (i_ready !== 1'b0)     begin errors++; $display("FAIL rst_i_ready: got %b, required 0", i_ready); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (i_ready !== 1'b1)     begin errors++; $display("FAIL post_rst_i_ready: got %b, required 1", i_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int w;
    o_ready = 1'b1;
    send(3'b000, 32'h0000_0001, 5'd31, 4'h3, w);
    vectors++; if (o_valid !== 1'b0) begin errors++; $display("FAIL latency_early: o_valid=%b one edge after accept, required 0", o_valid); end
    @(posedge clk); #1;
    vectors++; if (o_valid !== 1'b1) begin errors++; $display("FAIL latency: o_valid=%b two edges after accept, required 1", o_valid); end
    vectors++; if (o_data !== 32'h8000_0000) begin errors++; $display("FAIL sll31_data: got %h, required 80000000", o_data); end
    vectors++; if (o_tag !== 4'h3) begin errors++; $display("FAIL sll31_tag: got %h, required 3", o_tag); end
    wait_drain();
  endtask

  task automatic test_back_to_back;
    int w0, w1, w2;
    o_ready = 1'b1;
    send(3'b001, 32'h8000_0000, 5'd4, 4'h1, w0);
    send(3'b010, 32'h8000_0000, 5'd4, 4'h2, w1);
    send(3'b010, 32'h7FFF_FFFF, 5'd31, 4'h4, w2);
    vectors++;
    if (w0 != 0 || w1 != 0 || w2 != 0) begin
      errors++;
      $display("FAIL back_to_back_stall: waits %0d/%0d/%0d, required 0/0/0", w0, w1, w2);
    end
    wait_drain();
  endtask

  task automatic test_backpressure;
    int w;
    o_ready = 1'b0;
    send(3'b000, 32'h0000_00FF, 5'd8, 4'h5, w);
    send(3'b010, 32'h8000_0000, 5'd0, 4'h6, w);
    i_valid = 1'b1; i_op = 3'b001; i_data = 32'hFFFF_FFFF; i_shamt = 5'd31; i_tag = 4'h7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++; if (i_ready !== 1'b0) begin errors++; $display("FAIL stall_i_ready: cycle %0d got %b, required 0", c, i_ready); end
      vectors++; if (o_valid !== 1'b1 || o_data !== 32'h0000_FF00) begin
        errors++; $display("FAIL stall_hold: cycle %0d valid=%b data=%h, required 1/0000ff00", c, o_valid, o_data);
      end
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (!(i_ready === 1'b1 && o_valid === 1'b1)) begin
      errors++; $display("FAIL release_simul: i_ready=%b o_valid=%b, required 1/1", i_ready, o_valid);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_stall;
    int w;
    o_ready = 1'b0;
    send(3'b000, 32'h1234_5678, 5'd4, 4'h8, w);
    send(3'b001, 32'h1234_5678, 5'd4, 4'h9, w);
    rst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    vectors++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_o_valid: got %b, required 0", o_valid); end
    vectors++; if (o_data !== 32'h0) begin errors++; $display("FAIL midrst_o_data: got %h, required 0", o_data); end
    rst = 1'b1; o_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stale_after_rst: cycle %0d o_valid=%b, required 0", c, o_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    int w;
    o_ready = 1'b1;
    send(3'b111, 32'h1234_5678, 5'd3, 4'hA, w);
    @(posedge clk); #1;
    vectors++;
    if ({o_valid, o_illegal, o_tag, o_data} !== {1'b1, 1'b1, 4'hA, 32'h0}) begin
      errors++; $display("FAIL illegal_op: valid=%b ill=%b tag=%h data=%h, required 1/1/a/00000000", o_valid, o_illegal, o_tag, o_data);
    end
    wait_drain();
  endtask

  task automatic test_rotate;
    int w;
    logic [32:0] e [3];
`ifdef SHIFT_EXEC_ROTATE_EN
    e[0] = {1'b0, 32'h0000_0003}; e[1] = {1'b0, 32'h8000_0001}; e[2] = {1'b0, 32'hDEAD_BEEF};
`else
    e[0] = {1'b1, 32'h0}; e[1] = {1'b1, 32'h0}; e[2] = {1'b1, 32'h0};
`endif
    o_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: send(3'b011, 32'h8000_0001, 5'd1, 4'hB, w);
        1: send(3'b100, 32'h0000_0003, 5'd1, 4'hC, w);
        default: send(3'b100, 32'hDEAD_BEEF, 5'd0, 4'hD, w);
      endcase
      @(posedge clk); #1;
      vectors++;
      if ({o_illegal, o_data} !== e[k]) begin
        errors++; $display("FAIL rotate_%0d: ill=%b data=%h, required ill=%b data=%h", k, o_illegal, o_data, e[k][32], e[k][31:0]);
      end
      wait_drain();
    end
  endtask

  task automatic test_random;
    bit done;
    int w;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), w);
        end
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !done; c++) begin
          @(posedge clk); #1;
          o_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    o_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stall();
    test_illegal();
    test_rotate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
